// File: rtl/div_unit_if.sv
// Bundles the divider's request/response signals. The master side is the EX-stage
// controller; the slave side is the divider.
interface div_unit_if #(
   parameter int WIDTH = 32
);
   logic             flush;
   logic             hold;
   logic             start;
   logic             is_signed;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             stall_req;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;

   modport master (
      output flush, hold, start, is_signed, dividend, divisor,
      input  stall_req, done, quotient, remainder
   );

   modport slave (
      input  flush, hold, start, is_signed, dividend, divisor,
      output stall_req, done, quotient, remainder
   );
endinterface

// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU: one quotient bit per cycle on operand
// magnitudes. It raises the EX stall while busy and presents the result until hold drops.
module div_unit #(
   parameter int WIDTH = 32
) (
   input  logic        clk,
   input  logic        rst,
   div_unit_if.slave   bus
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           r_state;
   state_t           w_next_state;
   logic [CW-1:0]    r_count;
   logic [WIDTH:0]   r_rem;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_div;
   logic             r_neg_q;
   logic             r_neg_r;
   logic [WIDTH-1:0] r_quotient;
   logic [WIDTH-1:0] r_remainder;

   logic             w_dvd_neg;
   logic             w_dvs_neg;
   logic [WIDTH-1:0] w_dvd_abs;
   logic [WIDTH-1:0] w_dvs_abs;
   logic             w_div_zero;
   logic             w_accept;
   logic             w_last;
   logic [WIDTH:0]   w_shift;
   logic [WIDTH+1:0] w_diff;
   logic             w_fits;
   logic [WIDTH:0]   w_rem_next;
   logic [WIDTH-1:0] w_q_next;
   logic [WIDTH-1:0] w_rem_lo;
   logic [WIDTH-1:0] w_q_res;
   logic [WIDTH-1:0] w_r_res;

   assign w_dvd_neg  = bus.is_signed & bus.dividend[WIDTH-1];
   assign w_dvs_neg  = bus.is_signed & bus.divisor[WIDTH-1];
   assign w_dvd_abs  = w_dvd_neg ? -bus.dividend : bus.dividend;
   assign w_dvs_abs  = w_dvs_neg ? -bus.divisor  : bus.divisor;
   assign w_div_zero = (bus.divisor == '0);
   assign w_accept   = (r_state == S_IDLE) & bus.start & ~bus.flush;
   assign w_last     = (r_state == S_RUN) && (r_count == CW'(1));

   // Restoring step: shift in the next dividend bit, keep the difference if it fits.
   assign w_shift    = {r_rem[WIDTH-1:0], r_q[WIDTH-1]};
   assign w_diff     = {1'b0, w_shift} - {2'b00, r_div};
   assign w_fits     = ~w_diff[WIDTH+1];
   assign w_rem_next = w_fits ? w_diff[WIDTH:0] : w_shift;
   assign w_q_next   = {r_q[WIDTH-2:0], w_fits};
   assign w_rem_lo   = w_rem_next[WIDTH-1:0];
   assign w_q_res    = r_neg_q ? -w_q_next : w_q_next;
   assign w_r_res    = r_neg_r ? -w_rem_lo : w_rem_lo;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next_state;
   end

   // NOTE: next state is defaulted before any branch so no path can infer a latch.
   always_comb begin
      w_next_state = r_state;
      if (bus.flush) begin
         w_next_state = S_IDLE;
      end else begin
         unique case (r_state)
            S_IDLE: if (bus.start) w_next_state = w_div_zero ? S_DONE : S_RUN;
            S_RUN:  if (w_last)    w_next_state = S_DONE;
            S_DONE: if (!bus.hold) w_next_state = S_IDLE;
            default:               w_next_state = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count     <= '0;
         r_rem       <= '0;
         r_q         <= '0;
         r_div       <= '0;
         r_neg_q     <= 1'b0;
         r_neg_r     <= 1'b0;
         r_quotient  <= '0;
         r_remainder <= '0;
      end else if (w_accept) begin
         r_rem   <= '0;
         r_q     <= w_dvd_abs;
         r_div   <= w_dvs_abs;
         r_neg_q <= w_dvd_neg ^ w_dvs_neg;
         r_neg_r <= w_dvd_neg;
         if (w_div_zero) begin
            r_count     <= '0;
            r_quotient  <= '1;
            r_remainder <= bus.dividend;
         end else begin
            r_count     <= CW'(WIDTH);
         end
      end else if (r_state == S_RUN) begin
         if (bus.flush) begin
            r_count <= '0;
         end else begin
            r_rem   <= w_rem_next;
            r_q     <= w_q_next;
            r_count <= r_count - CW'(1);
            if (w_last) begin
               r_quotient  <= w_q_res;
               r_remainder <= w_r_res;
            end
         end
      end
   end

   // The stall drops in DONE so the controller releases EX in the cycle the result is valid.
   assign bus.stall_req = w_accept | ((r_state == S_RUN) & ~bus.flush);
   assign bus.done      = (r_state == S_DONE);
   assign bus.quotient  = r_quotient;
   assign bus.remainder = r_remainder;
endmodule
